i2cmb_wb_regs: RTL
==================

// Module: i2cmb_wb_regs
// PURPOSE
//  Wishbone slave register file at the host-facing edge of the I2CMB controller; consumes the cycles issued by the WB master.
//  Holds CSR/DPR/CMDR/FSMR, turns CMDR writes into a valid/ready command to the byte-level FSM.
//  Captures completion status and drives irq_o, which a CMDR read clears.
// PARAMETERS
//  ADDR_WIDTH  2   WB address width; only 0..3 decoded
//  DATA_WIDTH  8   WB data width
//  NUM_BUSES   16  number of I2C buses; valid bus IDs 0..NUM_BUSES-1
// PORTS
//  clk_i           in   1   system clock
//  rst_i           in   1   reset, asynchronous, active-high
//  cyc_i           in   1   WB cycle
//  stb_i           in   1   WB strobe
//  we_i            in   1   WB write enable
//  adr_i           in   2   WB address: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
//  dat_i           in   8   WB write data
//  dat_o           out  8   WB read data, valid with ack_o
//  ack_o           out  1   WB acknowledge, single-cycle pulse
//  irq_o           out  1   interrupt, level, to host
//  core_en_o       out  1   CSR.E; 0 holds downstream FSM in reset
//  cmd_valid_o     out  1   command request to byte FSM
//  cmd_ready_i     in   1   byte FSM accepts command
//  cmd_o           out  3   command code
//  cmd_data_o      out  8   DPR write byte, or bus ID for SET_BUS
//  done_i          in   1   one-cycle completion pulse from byte FSM
//  done_stat_i     in   2   00 DON, 01 NAK, 10 AL, 11 ERR
//  rx_data_i       in   8   received byte, valid with done_i
//  bus_busy_i      in   1   CSR.BB source
//  bus_cap_i       in   1   CSR.BC source
//  fsm_state_i     in   8   FSMR source, {byte_state[3:0], bit_state[3:0]}
// BEHAVIOUR
//  Reset, async on rst_i high: all outputs 0; CSR=0, DPR tx/rx=0, CMDR=8'h80 (DON=1), bus_id=0, state IDLE.
//  WB access:
//  - Request = cyc_i&stb_i&!ack_o sampled at posedge.
//  - ack_o high exactly the next cycle, low the cycle after; no back-to-back acks on one held request.
//  - Writes commit on the request edge. Reads register dat_o on the request edge, driven during ack_o; dat_o=0 otherwise.
//  CSR rd = {E,IE,BB,BC,bus_id[3:0]}. Writes update only E (bit7) and IE (bit6).
//  E 1->0: FSM forced to IDLE, cmd_valid_o dropped, irq_o cleared, CMDR=8'h80.
//  DPR: write -> tx byte; read -> last rx_data_i captured on done_i.
//  CMDR rd = {DON,NAK,AL,ERR,0,cmd[2:0]}; a read clears irq_o on the ack cycle (status bits persist).
//  FSMR: read-only, returns fsm_state_i; writes ignored.
//  Commands: 000 WAIT, 001 WRITE, 010 READ_ACK, 011 READ_NAK, 100 START, 101 STOP, 110 SET_BUS, 111 reserved.
//  FSM IDLE -> DISPATCH -> WAIT_DONE -> IDLE.
//  - IDLE: a CMDR write with E=1 clears status[7:4] and latches cmd/cmd_data (DPR, or dat... bus ID from DPR for SET_BUS).
//  - IDLE, legal command: -> DISPATCH, cmd_valid_o=1 the following cycle.
//  - IDLE, SET_BUS with DPR >= NUM_BUSES, or cmd 111: no dispatch; ERR=1 next cycle, irq if IE.
//  - DISPATCH: hold cmd_valid_o/cmd_o/cmd_data_o stable until cmd_valid_o&cmd_ready_i, then -> WAIT_DONE.
//  - WAIT_DONE: on done_i set status bit per done_stat_i, capture rx byte; SET_BUS success loads bus_id.
//  - WAIT_DONE exit: irq_o=1 next cycle if IE, -> IDLE.
//  - CMDR write while not IDLE, or with E=0: ignored, still acked.
//  - done_i outside WAIT_DONE: ignored.
//  - done_i coincident with a CMDR read: irq set wins.
//  - IE written 0 while irq_o=1: irq_o drops next cycle.
// TESTING
//  1. Reset mid-DISPATCH: assert rst_i asynchronously -> outputs 0 within same cycle; CMDR reads 8'h80.
//  2. Write CSR=8'hC0; read CSR -> 8'hC0; ack_o exactly 1 cycle after stb_i, dat_o valid with it.
//  3. DPR=8'h05, CMDR=8'h06 -> cmd_valid_o, cmd_o=110, cmd_data_o=05 held until ready.
//  3 (cont). done_i DON -> irq_o=1; CMDR read = 8'h86, irq_o low; CSR[3:0]=5.
//  4. DPR=8'h10 (NUM_BUSES=16), CMDR=8'h06 -> no cmd_valid_o; CMDR read = 8'h16; irq_o pulsed.
//  5. WRITE cmd with done_stat_i=01 -> CMDR=8'h41; second CMDR write during WAIT_DONE ignored.
//  6. READ_ACK, rx_data_i=8'hA5 -> DPR reads A5; ready held low 20 cycles -> cmd_valid_o stays high, signals stable.

Source files
------------

// File: rtl/i2cmb_wb_regs.sv
// Wishbone register file for the I2CMB controller: CSR/DPR/CMDR/FSMR, command
// hand-off to the byte-level FSM over valid/ready, and completion interrupt.
module i2cmb_wb_regs #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_BUSES  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  core_en_o,
    output logic                  cmd_valid_o,
    input  logic                  cmd_ready_i,
    output logic [2:0]            cmd_o,
    output logic [7:0]            cmd_data_o,
    input  logic                  done_i,
    input  logic [1:0]            done_stat_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_cap_i,
    input  logic [7:0]            fsm_state_i
);

    typedef enum logic [1:0] {StIdle, StDispatch, StWaitDone} state_e;

    localparam logic [ADDR_WIDTH-1:0] AdrCsr  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] AdrDpr  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AdrCmdr = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AdrFsmr = ADDR_WIDTH'(3);
    localparam logic [2:0]            CmdSetBus = 3'b110;

    state_e                state_q, state_d;
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  csr_e_q, csr_ie_q, irq_q;
    logic [3:0]            bus_id_q;
    logic [7:0]            dpr_tx_q, dpr_rx_q, cmd_data_q;
    logic [3:0]            status_q;  // {DON, NAK, AL, ERR}
    logic [2:0]            cmd_q;

    logic                  req, wr, rd, csr_wr, dpr_wr, cmdr_wr, cmdr_rd;
    logic                  e_drop, cmd_wr, cmd_illegal, done_ev;
    logic [DATA_WIDTH-1:0] rd_data;

    always_comb begin
        req         = cyc_i & stb_i & ~ack_q;
        wr          = req & we_i;
        rd          = req & ~we_i;
        csr_wr      = wr && (adr_i == AdrCsr);
        dpr_wr      = wr && (adr_i == AdrDpr);
        cmdr_wr     = wr && (adr_i == AdrCmdr);
        cmdr_rd     = rd && (adr_i == AdrCmdr);
        e_drop      = csr_wr & csr_e_q & ~dat_i[7];
        cmd_wr      = cmdr_wr & csr_e_q & (state_q == StIdle);
        cmd_illegal = (dat_i[2:0] == 3'b111) ||
                      ((dat_i[2:0] == CmdSetBus) && (32'(dpr_tx_q) >= NUM_BUSES));
        done_ev     = done_i & (state_q == StWaitDone);
    end

    always_comb begin
        rd_data = '0;
        unique case (adr_i)
            AdrCsr:  rd_data = DATA_WIDTH'({csr_e_q, csr_ie_q, bus_busy_i, bus_cap_i, bus_id_q});
            AdrDpr:  rd_data = DATA_WIDTH'(dpr_rx_q);
            AdrCmdr: rd_data = DATA_WIDTH'({status_q, 1'b0, cmd_q});
            AdrFsmr: rd_data = DATA_WIDTH'(fsm_state_i);
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (cmd_wr && !cmd_illegal) state_d = StDispatch;
            StDispatch: if (cmd_ready_i) state_d = StWaitDone;
            StWaitDone: if (done_i) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (e_drop) state_d = StIdle;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q      <= 1'b0;
            dat_q      <= '0;
            csr_e_q    <= 1'b0;
            csr_ie_q   <= 1'b0;
            irq_q      <= 1'b0;
            bus_id_q   <= '0;
            dpr_tx_q   <= '0;
            dpr_rx_q   <= '0;
            cmd_data_q <= '0;
            status_q   <= 4'b1000;
            cmd_q      <= '0;
        end else begin
            ack_q <= req;
            dat_q <= rd ? rd_data : '0;
            if (csr_wr) begin
                csr_e_q  <= dat_i[7];
                csr_ie_q <= dat_i[6];
            end
            if (dpr_wr) dpr_tx_q <= dat_i[7:0];
            if (cmd_wr) begin
                cmd_q      <= dat_i[2:0];
                cmd_data_q <= dpr_tx_q;
                status_q   <= cmd_illegal ? 4'b0001 : 4'b0000;
            end
            if (done_ev) begin
                status_q <= 4'b1000 >> done_stat_i;
                dpr_rx_q <= rx_data_i;
                if (cmd_q == CmdSetBus && done_stat_i == 2'b00) bus_id_q <= cmd_data_q[3:0];
            end
            if (e_drop) begin
                status_q <= 4'b1000;
                cmd_q    <= '0;
            end
            // Disable and IE-clear dominate; a new completion beats a CMDR read clear.
            if (e_drop || (csr_wr && !dat_i[6]))                          irq_q <= 1'b0;
            else if ((done_ev || (cmd_wr && cmd_illegal)) && csr_ie_q)    irq_q <= 1'b1;
            else if (cmdr_rd)                                             irq_q <= 1'b0;
        end
    end

    assign dat_o       = dat_q;
    assign ack_o       = ack_q;
    assign irq_o       = irq_q;
    assign core_en_o   = csr_e_q;
    assign cmd_valid_o = (state_q == StDispatch);
    assign cmd_o       = cmd_q;
    assign cmd_data_o  = cmd_data_q;

endmodule
